// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core: one shared req/ready memory port for fetch and data,
// with a 3-5 cycle FSM per instruction and sticky TRAP on misalignment, bad opcode or timeout.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [3:0]        state,
  output logic              retire,
  output logic              trap
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  function automatic logic r_funct_ok(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_r(input logic [5:0] f, input logic [4:0] shamt,
                                        input logic signed [31:0] a, input logic signed [31:0] b);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_SLT:   return {31'b0, (a < b)};
      F_SLL:   return b << shamt;
      F_SRL:   return b >> shamt;
      default: return 32'h0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        mdr_q, mdr_d;
  logic signed [31:0] a_q, a_d;
  logic signed [31:0] b_q, b_d;
  logic [31:0]        alu_q, alu_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        tcnt_q, tcnt_d;
  logic [31:0]        rf_q [32];

  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               retire_c;
  logic               accept;
  logic signed [31:0] diff;
  logic [31:0]        addr_full;

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rs, rt, rd, shamt;
  logic signed [31:0] simm;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};

  // Ready is only meaningful while a request is actually on the port.
  assign accept = req_q & mem_ready;
  assign diff   = a_q - b_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    tcnt_d   = 32'h0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    retire_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (accept) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = pc_q + {simm[29:0], 2'b00};
        case (op)
          OP_RTYPE: begin
            if (funct == F_JR)          state_d = S_JR;
            else if (r_funct_ok(funct)) state_d = S_EXEC_R;
            else                        state_d = S_TRAP;
          end
          OP_ADDI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_d   = alu_r(funct, shamt, a_q, b_q);
        state_d = S_WB_R;
      end
      S_WB_R: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = alu_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_d   = a_q + simm;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = alu_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_d = a_q + simm;
        if (alu_d[1:0] != 2'b00) state_d = S_TRAP;
        else if (op == OP_LW)    state_d = S_MEM_RD;
        else                     state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (accept) begin
          mdr_d   = mem_rdata;
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        if (accept) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BRANCH: begin
        if ((op == OP_BEQ) == (diff == 32'sd0)) pc_d = alu_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        if (op == OP_JAL) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc_q;
        end
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pc_d     = a_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Timeout only fires when ready is absent, so a same-cycle ready completes the access.
    if ((TIMEOUT > 0) && req_q && !mem_ready) begin
      tcnt_d = tcnt_q + 32'd1;
      if (tcnt_d == 32'(TIMEOUT)) state_d = S_TRAP;
    end

    req_d = (state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    we_d  = (state_d == S_MEM_WR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      mdr_q   <= 32'h0;
      a_q     <= 32'sh0;
      b_q     <= 32'sh0;
      alu_q   <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      tcnt_q  <= 32'h0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      req_q   <= req_d;
      we_q    <= we_d;
      tcnt_q  <= tcnt_d;
      if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // PC and ALUOut are frozen during a wait, which keeps the address stable until acceptance.
  assign addr_full = (state_q == S_FETCH) ? pc_q : alu_q;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign retire    = retire_c & ~reset;
  assign trap      = (state_q == S_TRAP);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs run against a word memory model
// with configurable wait states, plus a second instance with a memory timeout.
module tb_mips_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]  state;
  logic        retire, trap;

  logic        to_reset = 1'b1;
  logic        to_req, to_we, to_retire, to_trap;
  logic [31:0] to_addr, to_wdata, to_pc;
  logic [3:0]  to_state;
  logic        to_ready = 1'b0;
  logic [31:0] to_rdata = 32'h0;

  logic [31:0] mem [0:1023];
  int          wcnt     = 0;
  int          wait_cfg = 0;
  logic        ld_en    = 1'b0;
  logic        ld_clr   = 1'b0;
  logic [31:0] ld_addr  = 32'h0;
  logic [31:0] ld_data  = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mips_multicycle #(.RESET_PC(32'h0), .ADDR_W(32), .TIMEOUT(0)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .state(state), .retire(retire), .trap(trap)
  );

  mips_multicycle #(.RESET_PC(32'h0), .ADDR_W(32), .TIMEOUT(4)) dut_to (
    .clock(clock), .reset(to_reset), .mem_req(to_req), .mem_we(to_we),
    .mem_addr(to_addr), .mem_wdata(to_wdata), .mem_rdata(to_rdata),
    .mem_ready(to_ready), .pc(to_pc), .state(to_state), .retire(to_retire), .trap(to_trap)
  );

  // Memory model: ready after wait_cfg cycles of a held request; load port used under reset.
  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = mem_req && (wcnt >= wait_cfg);

  always @(posedge clock) begin
    if (ld_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (ld_en) begin
      mem[ld_addr[11:2]] <= ld_data;
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clock);
    ld_en   = 1'b0;
  endtask

  task automatic start(input int wcfg);
    reset = 1'b1;
    @(negedge clock);
    ld_clr = 1'b1;
    @(negedge clock);
    ld_clr   = 1'b0;
    wait_cfg = wcfg;
  endtask

  task automatic go();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs until nret retire pulses; cycles counted from the first cycle with mem_req high.
  task automatic run_prog(input int nret, output int cycles);
    int r, c, guard;
    bit started, pw;
    logic [31:0] sa, sd;
    logic swe;
    r = 0; c = 0; guard = 0; started = 0; pw = 0; sa = 0; sd = 0; swe = 0;
    while (r < nret && guard < 400) begin
      @(negedge clock);
      guard++;
      if (mem_req) started = 1;
      if (started) c++;
      if (pw && mem_req) begin
        chk("stable_addr", mem_addr, sa);
        chk("stable_we", 32'(mem_we), 32'(swe));
        chk("stable_wdata", mem_wdata, sd);
      end
      pw  = mem_req && !mem_ready;
      sa  = mem_addr;
      swe = mem_we;
      sd  = mem_wdata;
      if (retire) r++;
    end
    chk("retire_count", 32'(r), 32'(nret));
    cycles = c;
  endtask

  task automatic load_main();
    load(32'h00, 32'h20010005);  // addi $1,$0,5
    load(32'h04, 32'h20020007);  // addi $2,$0,7
    load(32'h08, 32'h00221820);  // add  $3,$1,$2
    load(32'h0C, 32'hAC030040);  // sw   $3,0x40($0)
    load(32'h10, 32'h8C040040);  // lw   $4,0x40($0)
    load(32'h14, 32'h1000FFFF);  // beq  $0,$0,-1
  endtask

  initial begin
    int cyc, n;

    // Reset values
    start(0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);

    // Timeout with ready tied low: trap 4 cycles after the request first asserts
    @(negedge clock);
    to_reset = 1'b0;
    n = 0;
    while (!to_req && n < 10) begin @(negedge clock); n++; end
    chk("to_req_seen", 32'(to_req), 32'd1);
    n = 0;
    while (!to_trap && n < 20) begin @(negedge clock); n++; end
    chk("to_trap_delay", 32'(n), 32'd4);
    chk("to_state", 32'(to_state), 32'd15);
    @(negedge clock);
    chk("to_req_after", 32'(to_req), 32'd0);

    // Zero-wait program
    start(0);
    load_main();
    go();
    run_prog(5, cyc);
    @(negedge clock);
    chk("zw_cycles", 32'(cyc), 32'd21);
    chk("zw_r3", dut.rf_q[3], 32'd12);
    chk("zw_r4", dut.rf_q[4], 32'd12);
    chk("zw_mem40", mem[16], 32'd12);

    // Same program with 3 wait cycles on every access
    start(3);
    load_main();
    go();
    run_prog(5, cyc);
    @(negedge clock);
    chk("ws_cycles", 32'(cyc), 32'd42);
    chk("ws_r3", dut.rf_q[3], 32'd12);
    chk("ws_r4", dut.rf_q[4], 32'd12);
    chk("ws_mem40", mem[16], 32'd12);

    // ALU operations
    start(0);
    load(32'h00, 32'h2001FFFD);  // addi $1,$0,-3
    load(32'h04, 32'h20020005);  // addi $2,$0,5
    load(32'h08, 32'h00221822);  // sub  $3,$1,$2
    load(32'h0C, 32'h0022202A);  // slt  $4,$1,$2
    load(32'h10, 32'h00022900);  // sll  $5,$2,4
    load(32'h14, 32'h00013702);  // srl  $6,$1,28
    load(32'h18, 32'h00223824);  // and  $7,$1,$2
    load(32'h1C, 32'h00224025);  // or   $8,$1,$2
    load(32'h20, 32'h1000FFFF);
    go();
    run_prog(8, cyc);
    @(negedge clock);
    chk("alu_cycles", 32'(cyc), 32'd32);
    chk("alu_sub", dut.rf_q[3], 32'hFFFFFFF8);
    chk("alu_slt", dut.rf_q[4], 32'd1);
    chk("alu_sll", dut.rf_q[5], 32'h50);
    chk("alu_srl", dut.rf_q[6], 32'hF);
    chk("alu_and", dut.rf_q[7], 32'd5);
    chk("alu_or", dut.rf_q[8], 32'hFFFFFFFD);

    // Control flow: bne not taken, j, jal, jr
    start(0);
    load(32'h000, 32'h14000005);  // bne $0,$0,+5
    load(32'h004, 32'h08000040);  // j   0x100
    load(32'h100, 32'h0C000080);  // jal 0x200
    load(32'h200, 32'h03E00008);  // jr  $31
    load(32'h104, 32'h1000FFFF);
    go();
    run_prog(1, cyc);
    chk("bne_cycles", 32'(cyc), 32'd3);
    @(negedge clock);
    chk("bne_pc", pc, 32'h4);
    run_prog(1, cyc);
    @(negedge clock);
    chk("j_pc", pc, 32'h100);
    run_prog(1, cyc);
    @(negedge clock);
    chk("jal_pc", pc, 32'h200);
    chk("jal_r31", dut.rf_q[31], 32'h104);
    run_prog(1, cyc);
    @(negedge clock);
    chk("jr_pc", pc, 32'h104);

    // beq taken with offset -1: loops on itself every 3 cycles
    start(0);
    load(32'h0, 32'h1000FFFF);
    go();
    run_prog(1, cyc);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      @(negedge clock);
      n++;
      chk("beq_pc", pc, 32'h0);
      while (!retire && n < 20) begin @(negedge clock); n++; end
      chk("beq_period", 32'(n), 32'd3);
    end

    // $0 stays zero
    start(0);
    load(32'h0, 32'h20000009);  // addi $0,$0,9
    load(32'h4, 32'h00002820);  // add  $5,$0,$0
    load(32'h8, 32'h1000FFFF);
    go();
    run_prog(2, cyc);
    @(negedge clock);
    chk("zero_r5", dut.rf_q[5], 32'd0);
    chk("zero_r0", dut.rf_q[0], 32'd0);

    // Misaligned lw traps and never requests again
    start(0);
    load(32'h0, 32'h8C010042);  // lw $1,0x42($0)
    go();
    n = 0;
    while (!trap && n < 30) begin @(negedge clock); n++; end
    chk("mis_trap", 32'(trap), 32'd1);
    chk("mis_state", 32'(state), 32'd15);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("mis_req", 32'(mem_req), 32'd0);
    end

    // Illegal opcode traps
    start(0);
    load(32'h0, 32'hFC000000);
    go();
    n = 0;
    while (!trap && n < 30) begin @(negedge clock); n++; end
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_state", 32'(state), 32'd15);

    // Reset in the middle of a store wait abandons the store
    start(3);
    load(32'h0, 32'h20010005);  // addi $1,$0,5
    load(32'h4, 32'hAC010040);  // sw   $1,0x40($0)
    load(32'h40, 32'h0000DEAD);
    go();
    n = 0;
    while (!(state == 4'd9 && mem_req && wcnt == 1) && n < 100) begin @(negedge clock); n++; end
    chk("mr_in_wait", 32'(state), 32'd9);
    chk("mr_r1_before", dut.rf_q[1], 32'd5);
    reset = 1'b1;
    @(negedge clock);
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_pc", pc, 32'h0);
    chk("mr_r1", dut.rf_q[1], 32'd0);
    chk("mr_alu", dut.alu_q, 32'd0);
    @(negedge clock);
    chk("mr_mem40", mem[16], 32'h0000DEAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
